// File: rtl/controller_tc_status_input.sv
// controller_tc_status_input
// Avalon-MM zero-wait-state PIO input port for the TC status lines.
// Each line is synchronised, debounced, and edge-captured. A level IRQ is
// raised whenever a captured edge is enabled in the interrupt mask.
module controller_tc_status_input #(
  parameter int               WIDTH        = 4,
  parameter int               EDGE_TYPE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [15:0]      DEBOUNCE_RST = 16'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] filtered_nxt;
  logic [15:0]      debounce;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap_clr;
  logic [15:0]      cnt     [WIDTH];
  logic [15:0]      cnt_nxt [WIDTH];
  logic             wr;
  logic             unused_writedata;

  assign wr = chipselect & ~write_n;

  // Only the low 16 bits of the write bus reach any register.
  assign unused_writedata = ^writedata[31:16];

  // Two-flop synchroniser bringing the asynchronous lines into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: filtered follows sync2 only after N+1 consecutive differing cycles.
  always_comb begin
    filtered_nxt = filtered;
    cnt_nxt      = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == filtered[i]) begin
        cnt_nxt[i] = 16'd0;
      end else if (cnt[i] == debounce) begin
        filtered_nxt[i] = sync2[i];
        cnt_nxt[i]      = 16'd0;
      end else begin
        cnt_nxt[i] = cnt[i] + 16'd1;
      end
    end
  end

  // Edge detection on the filtered value in the configured direction, plus W1C clear mask.
  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = filtered_nxt & ~filtered;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~filtered_nxt & filtered;
    end else begin
      edge_det = filtered_nxt ^ filtered;
    end
    edgecap_clr = '0;
    if (wr && (address == ADDR_EDGECAP)) begin
      edgecap_clr = writedata[WIDTH-1:0];
    end
  end

  // Filtered state and debounce counters; a reset discards any count in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= 16'd0;
      end
    end else begin
      filtered <= filtered_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Software-visible registers; a newly captured edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounce <= DEBOUNCE_RST;
      irqmask  <= '0;
      edgecap  <= '0;
    end else begin
      if (wr && (address == ADDR_DEBOUNCE)) begin
        debounce <= writedata[15:0];
      end
      if (wr && (address == ADDR_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~edgecap_clr) | edge_det;
    end
  end

  // Zero-latency read mux; unused bits read as zero.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = filtered;
      ADDR_DEBOUNCE: readdata[15:0]      = debounce;
      ADDR_IRQMASK:  readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP:  readdata[WIDTH-1:0] = edgecap;
      default:       readdata            = 32'd0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_controller_tc_status_input.sv
// tb_controller_tc_status_input
// Directed bench with a scoreboard: each read pushes its expected readdata/irq
// into a queue, and a monitor pops and compares when a read is presented.
module tb_controller_tc_status_input;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic        mon_req;
  exp_t        sbq[$];
  int          checks;
  int          failures;

  controller_tc_status_input #(
    .WIDTH(4),
    .EDGE_TYPE(0),
    .RESET_VALUE(4'h0),
    .DEBOUNCE_RST(16'd0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever a read is presented, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (mon_req) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if ((readdata !== e.data) || (irq !== e.irq)) begin
          failures++;
          $display("[TB] FAIL %s: readdata=%08h irq=%0b, expected readdata=%08h irq=%0b",
                   e.name, readdata, irq, e.data, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Register write; takes effect at the next rising edge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  // Present a read for one cycle and queue its expected readdata and irq.
  task automatic checkOutput(input string name, input logic [1:0] addr,
                             input logic [31:0] data, input logic exp_irq);
    exp_t e;
    e.name     = name;
    e.data     = data;
    e.irq      = exp_irq;
    sbq.push_back(e);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    mon_req    = 1'b1;
    @(posedge clk);
    #1;
    mon_req    = 1'b0;
    chipselect = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    checks     = 0;
    failures   = 0;
    mon_req    = 1'b0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;
    tick(1);

    // Reset state on all addresses while reset is held.
    checkOutput("rst_data",     2'd0, 32'h0, 1'b0);
    checkOutput("rst_debounce", 2'd1, 32'h0, 1'b0);
    checkOutput("rst_irqmask",  2'd2, 32'h0, 1'b0);
    checkOutput("rst_edgecap",  2'd3, 32'h0, 1'b0);

    // Release: DATA follows in_port after three edges; the 0->F change is a rising edge.
    reset_n = 1'b1;
    checkOutput("rel_edgecap0", 2'd3, 32'h0, 1'b0);
    checkOutput("rel_data_e1",  2'd0, 32'h0, 1'b0);
    checkOutput("rel_data_e2",  2'd0, 32'h0, 1'b0);
    checkOutput("rel_data_e3",  2'd0, 32'hF, 1'b0);
    checkOutput("rel_edgecapF", 2'd3, 32'hF, 1'b0);
    applyStimulus(2'd3, 32'hF);
    checkOutput("rel_clear",    2'd3, 32'h0, 1'b0);

    // N=0, mask bit0, rising edge on bit0.
    applyStimulus(2'd2, 32'h1);
    checkOutput("t2_mask",      2'd2, 32'h1, 1'b0);
    in_port = 4'hE;
    tick(4);
    checkOutput("t2_data_low",  2'd0, 32'hE, 1'b0);
    checkOutput("t2_fall_nocap",2'd3, 32'h0, 1'b0);
    in_port = 4'hF;
    checkOutput("t2_lat_1",     2'd0, 32'hE, 1'b0);
    checkOutput("t2_lat_2",     2'd0, 32'hE, 1'b0);
    checkOutput("t2_lat_3",     2'd0, 32'hE, 1'b0);
    checkOutput("t2_lat_4",     2'd0, 32'hF, 1'b1);
    checkOutput("t2_edgecap",   2'd3, 32'h1, 1'b1);
    applyStimulus(2'd3, 32'h1);
    checkOutput("t2_w1c",       2'd3, 32'h0, 1'b0);

    // Debounce N=5: a 5-cycle pulse is rejected, a held level lands 8 edges later.
    applyStimulus(2'd1, 32'h5);
    checkOutput("t3_debounce",  2'd1, 32'h5, 1'b0);
    in_port = 4'hD;
    tick(12);
    checkOutput("t3_base",      2'd0, 32'hD, 1'b0);
    in_port = 4'hF;
    tick(5);
    in_port = 4'hD;
    tick(10);
    checkOutput("t3_glitch_data", 2'd0, 32'hD, 1'b0);
    checkOutput("t3_glitch_cap",  2'd3, 32'h0, 1'b0);
    in_port = 4'hF;
    tick(7);
    checkOutput("t3_hold_e8pre",  2'd0, 32'hD, 1'b0);
    checkOutput("t3_hold_e8",     2'd0, 32'hF, 1'b0);
    checkOutput("t3_hold_cap",    2'd3, 32'h2, 1'b0);

    // Clear and set on bit1 in the same cycle: the set wins.
    applyStimulus(2'd2, 32'h2);
    checkOutput("t4_irq_on",    2'd3, 32'h2, 1'b1);
    applyStimulus(2'd1, 32'h0);
    in_port = 4'hD;
    tick(5);
    in_port = 4'hF;
    tick(2);
    applyStimulus(2'd3, 32'h2);
    checkOutput("t4_collide",   2'd3, 32'h2, 1'b1);
    checkOutput("t4_data",      2'd0, 32'hF, 1'b1);
    applyStimulus(2'd3, 32'h2);
    checkOutput("t4_clear",     2'd3, 32'h0, 1'b0);

    // Mask gating of irq, and writes to the read-only DATA register.
    applyStimulus(2'd2, 32'h0);
    in_port = 4'hB;
    tick(4);
    in_port = 4'hF;
    tick(4);
    checkOutput("t5_masked",    2'd3, 32'h4, 1'b0);
    applyStimulus(2'd2, 32'h4);
    checkOutput("t5_unmask",    2'd2, 32'h4, 1'b1);
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    checkOutput("t5_ro_data",   2'd0, 32'hF, 1'b1);
    checkOutput("t5_ro_deb",    2'd1, 32'h0, 1'b1);
    checkOutput("t5_ro_mask",   2'd2, 32'h4, 1'b1);
    checkOutput("t5_ro_cap",    2'd3, 32'h4, 1'b1);

    // Reset at count 7 of an N=10 debounce discards the count.
    applyStimulus(2'd1, 32'd10);
    in_port = 4'hB;
    tick(9);
    reset_n = 1'b0;
    checkOutput("t6_rst_data",  2'd0, 32'h0, 1'b0);
    checkOutput("t6_rst_deb",   2'd1, 32'h0, 1'b0);
    checkOutput("t6_rst_mask",  2'd2, 32'h0, 1'b0);
    checkOutput("t6_rst_cap",   2'd3, 32'h0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(2'd1, 32'd10);
    tick(11);
    checkOutput("t6_cnt_fresh", 2'd0, 32'h0, 1'b0);
    checkOutput("t6_cnt_done",  2'd0, 32'hB, 1'b0);
    checkOutput("t6_cap",       2'd3, 32'hB, 1'b0);

    tick(2);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
